// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle micro-op controller sitting between the
// instruction decoder and the cpu datapath. One command at a time is accepted
// over cmd_valid/cmd_ready, then walked through READ -> EXEC -> (MEM ->
// MEM_WAIT) -> WB, ending with a one-cycle done_valid pulse.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_*                 command handshake + payload (op, alu_op, rs1/rs2/rd, imm)
//   rf_addr_a/b, rf_data_a/b          register-file read port
//   rf_write_en/addr/data             register-file write port
//   alu_input_a/b, alu_operation,
//   alu_result, alu_overflow          ALU interface
//   dm_addr, dm_data_input,
//   dm_write_en, dm_data_output       data memory (synchronous read)
//   done_valid, done_overflow         completion pulse + overflow of that op
//   trap                              sticky overflow trap
//
// Build option: define OVERFLOW_TRAP_EN to make an overflowing ALU op drop its
// writeback and raise a sticky trap that blocks new commands until reset.
// Without it trap is tied 0 and overflowing results are written normally.
module datapath_sequencer #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [2:0]          cmd_alu_op,
  input  logic [4:0]          cmd_rs1,
  input  logic [4:0]          cmd_rs2,
  input  logic [4:0]          cmd_rd,
  input  logic [WORDSIZE-1:0] cmd_imm,
  output logic [4:0]          rf_addr_a,
  output logic [4:0]          rf_addr_b,
  input  logic [WORDSIZE-1:0] rf_data_a,
  input  logic [WORDSIZE-1:0] rf_data_b,
  output logic                rf_write_en,
  output logic [4:0]          rf_write_addr,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic [WORDSIZE-1:0] alu_input_a,
  output logic [WORDSIZE-1:0] alu_input_b,
  output logic [2:0]          alu_operation,
  input  logic [WORDSIZE-1:0] alu_result,
  input  logic                alu_overflow,
  output logic [WORDSIZE-1:0] dm_addr,
  output logic [WORDSIZE-1:0] dm_data_input,
  output logic                dm_write_en,
  input  logic [WORDSIZE-1:0] dm_data_output,
  output logic                done_valid,
  output logic                done_overflow,
  output logic                trap
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, MEM_WAIT, WB} state_t;

  localparam logic [1:0] OP_RR    = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RI    = 2'b11;

  state_t state, state_nxt;

  // Latched command and per-stage captures. All datapath-facing address/data
  // outputs are driven straight from these, so they hold their last value
  // between ops and are 0 after reset.
  logic [1:0]          op_q;
  logic [2:0]          alu_op_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [WORDSIZE-1:0] imm_q, opa_q, opb_q, res_q, ld_q;
  logic                ovf_q;

  logic accept, is_alu, trap_q, suppress_wb;

  assign is_alu = (op_q == OP_RR) || (op_q == OP_RI);
  assign accept = cmd_valid & cmd_ready;

`ifdef OVERFLOW_TRAP_EN
  // An overflowing ALU op is not committed; the trap latches at its WB.
  assign suppress_wb = is_alu & ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          trap_q <= 1'b0;
    else if (state == WB && suppress_wb) trap_q <= 1'b1;
  end
`else
  assign suppress_wb = 1'b0;
  assign trap_q      = 1'b0;
`endif

  assign trap = trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      alu_op_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ld_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= cmd_op;
        alu_op_q <= cmd_alu_op;
        rs1_q    <= cmd_rs1;
        rs2_q    <= cmd_rs2;
        rd_q     <= cmd_rd;
        imm_q    <= cmd_imm;
      end
      if (state == READ) begin
        opa_q <= rf_data_a;
        opb_q <= rf_data_b;
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        ovf_q <= alu_overflow;
      end
      // Memory is synchronous-read: data for dm_addr set in MEM is valid here.
      if (state == MEM_WAIT) ld_q <= dm_data_output;
    end
  end

  // Held-value datapath outputs.
  assign rf_addr_a     = rs1_q;
  assign rf_addr_b     = rs2_q;
  assign alu_input_a   = opa_q;
  assign alu_input_b   = (op_q == OP_RR) ? opb_q : imm_q;
  // LOAD/STORE use the ALU purely as an address adder.
  assign alu_operation = is_alu ? alu_op_q : 3'b000;
  assign dm_addr       = res_q;
  assign dm_data_input = opb_q;
  assign rf_write_addr = rd_q;
  assign rf_write_data = (op_q == OP_LOAD) ? ld_q : res_q;

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    rf_write_en   = 1'b0;
    dm_write_en   = 1'b0;
    done_valid    = 1'b0;
    done_overflow = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~trap_q;
        if (accept) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = is_alu ? WB : MEM;
      MEM: begin
        if (op_q == OP_STORE) begin
          dm_write_en = 1'b1;
          done_valid  = 1'b1;
          state_nxt   = IDLE;
        end else begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: state_nxt = WB;
      WB: begin
        // R0 is hardwired zero in the register file; never write it.
        rf_write_en   = (rd_q != 5'd0) && !suppress_wb;
        done_valid    = 1'b1;
        done_overflow = is_alu & ovf_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboarded bench for datapath_sequencer. The bench models the register
// file, a small ALU and a synchronous-read data memory around the DUT. Each
// issued command pushes its expected completion; a negedge monitor pops and
// compares whenever done_valid is seen.
module tb_datapath_sequencer;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_alu_op;
  logic [4:0]    cmd_rs1, cmd_rs2, cmd_rd;
  logic [W-1:0]  cmd_imm;
  logic [4:0]    rf_addr_a, rf_addr_b;
  logic [W-1:0]  rf_data_a, rf_data_b;
  logic          rf_write_en;
  logic [4:0]    rf_write_addr;
  logic [W-1:0]  rf_write_data;
  logic [W-1:0]  alu_input_a, alu_input_b;
  logic [2:0]    alu_operation;
  logic [W-1:0]  alu_result;
  logic          alu_overflow;
  logic [W-1:0]  dm_addr, dm_data_input;
  logic          dm_write_en;
  logic [W-1:0]  dm_data_output;
  logic          done_valid, done_overflow, trap;

  datapath_sequencer #(.WORDSIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_alu_op(cmd_alu_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .alu_overflow(alu_overflow),
    .dm_addr(dm_addr), .dm_data_input(dm_data_input),
    .dm_write_en(dm_write_en), .dm_data_output(dm_data_output),
    .done_valid(done_valid), .done_overflow(done_overflow), .trap(trap)
  );

  always #5 clk = ~clk;

  // ---------------- datapath models ----------------
  logic [W-1:0] rf  [0:31];
  logic [W-1:0] mem [0:255];
  logic         poke;
  logic [4:0]   poke_addr;
  logic [W-1:0] poke_data;

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk) begin
    if (poke) rf[poke_addr] <= poke_data;
    else if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end

  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  always @(posedge clk) begin
    if (dm_write_en) mem[dm_addr[7:0]] <= dm_data_input;
    dm_data_output <= mem[dm_addr[7:0]];
  end

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor; signed overflow on add/sub.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_operation)
      3'd0: begin
        alu_result   = alu_input_a + alu_input_b;
        alu_overflow = (alu_input_a[W-1] == alu_input_b[W-1]) &&
                       (alu_result[W-1] != alu_input_a[W-1]);
      end
      3'd1: begin
        alu_result   = alu_input_a - alu_input_b;
        alu_overflow = (alu_input_a[W-1] != alu_input_b[W-1]) &&
                       (alu_result[W-1] != alu_input_a[W-1]);
      end
      3'd2: alu_result = alu_input_a & alu_input_b;
      3'd3: alu_result = alu_input_a | alu_input_b;
      3'd4: alu_result = alu_input_a ^ alu_input_b;
      default: alu_result = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  localparam int K_WB = 0, K_NOWB = 1, K_ST = 2;

  typedef struct {
    int           kind;
    logic [4:0]   rd;
    logic [W-1:0] data;
    logic         ovf;
    logic [W-1:0] addr;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_write_en && !done_valid) chk("stray_rf_write_en", rf_write_en, 1'b0);
      if (dm_write_en && !done_valid) chk("stray_dm_write_en", dm_write_en, 1'b0);
      if (done_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_done", done_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", W'(cyc - e.acc + 1), W'(e.lat));
          chk("done_overflow", done_overflow, e.ovf);
          case (e.kind)
            K_WB: begin
              chk("rf_write_en", rf_write_en, 1'b1);
              chk("rf_write_addr", rf_write_addr, e.rd);
              chk("rf_write_data", rf_write_data, e.data);
            end
            K_NOWB: chk("rf_write_en_off", rf_write_en, 1'b0);
            default: begin
              chk("dm_write_en", dm_write_en, 1'b1);
              chk("dm_addr", dm_addr, e.addr);
              chk("dm_data_input", dm_data_input, e.data);
              chk("store_rf_write_en", rf_write_en, 1'b0);
            end
          endcase
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic garbage();
    cmd_valid  = 1'b1;
    cmd_op     = 2'($urandom);
    cmd_alu_op = 3'($urandom);
    cmd_rs1    = 5'($urandom);
    cmd_rs2    = 5'($urandom);
    cmd_rd     = 5'($urandom_range(10, 31));
    cmd_imm    = {$urandom, $urandom};
  endtask

  task automatic preload(input logic [4:0] a, input logic [W-1:0] d);
    poke = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke = 1'b0;
  endtask

  // Called at a negedge. Drives the command, waits for acceptance, pushes the
  // expectation, then (if wait_rdy) returns at the negedge where the DUT is
  // ready again. With hold set, valid stays high with junk payload while busy.
  task automatic issue(input logic [1:0] op, input logic [2:0] aop,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [W-1:0] imm,
                       input bit hold, input bit wait_rdy, input int kind,
                       input logic [W-1:0] edata, input logic eovf,
                       input logic [W-1:0] eaddr, input int lat);
    exp_t e;
    int   n;
    cmd_valid = 1'b1; cmd_op = op; cmd_alu_op = aop;
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.kind = kind; e.rd = rd; e.data = edata; e.ovf = eovf;
    e.addr = eaddr; e.acc = cyc; e.lat = lat;
    q.push_back(e);
    #1;
    if (hold) garbage();
    else cmd_valid = 1'b0;
    @(negedge clk);
    if (wait_rdy) begin
      n = 0;
      while (!cmd_ready && n < 50) begin
        if (hold) garbage();
        @(negedge clk);
        n++;
      end
      if (!cmd_ready) chk("ready_timeout", cmd_ready, 1'b1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rf_write_en"}, rf_write_en, 1'b0);
    chk({tag, "_dm_write_en"}, dm_write_en, 1'b0);
    chk({tag, "_done_valid"}, done_valid, 1'b0);
    chk({tag, "_done_overflow"}, done_overflow, 1'b0);
    chk({tag, "_trap"}, trap, 1'b0);
    chk({tag, "_rf_addr_a"}, rf_addr_a, '0);
    chk({tag, "_dm_addr"}, dm_addr, '0);
    chk({tag, "_alu_input_a"}, alu_input_a, '0);
    chk({tag, "_rf_write_data"}, rf_write_data, '0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; poke = 1'b0; poke_addr = '0; poke_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_alu_op = '0;
    cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    preload(5'd1, 64'd5);
    preload(5'd2, 64'd7);

    // reg-reg add: R3 = 5 + 7
    issue(2'b00, 3'd0, 5'd1, 5'd2, 5'd3, 64'h0, 0, 1, K_WB, 64'd12, 0, 0, 3);
    chk("r3_model", rf[3], 64'd12);

    // STORE then LOAD; alu_op=sub must be ignored (address is always an add)
    preload(5'd1, 64'h40);
    preload(5'd2, 64'hDEAD);
    issue(2'b10, 3'd1, 5'd1, 5'd2, 5'd0, 64'h8, 0, 1, K_ST, 64'hDEAD, 0, 64'h48, 3);
    issue(2'b01, 3'd1, 5'd1, 5'd0, 5'd4, 64'h8, 0, 1, K_WB, 64'hDEAD, 0, 0, 5);
    chk("r4_model", rf[4], 64'hDEAD);

    // rd = 0: completes without a write
    issue(2'b11, 3'd0, 5'd1, 5'd0, 5'd0, 64'h1, 0, 1, K_NOWB, 0, 0, 0, 3);

    // reg-reg sub: 0xDEAD - 0x40
    issue(2'b00, 3'd1, 5'd2, 5'd1, 5'd6, 64'h0, 0, 1, K_WB, 64'hDE6D, 0, 0, 3);

    // STORE whose address add overflows: done_overflow stays 0
    preload(5'd11, 64'h7FFF_FFFF_FFFF_FFFF);
    issue(2'b10, 3'd0, 5'd11, 5'd2, 5'd0, 64'h1, 0, 1, K_ST, 64'hDEAD, 0,
          64'h8000_0000_0000_0000, 3);

    // valid held high with junk payload while busy; only accepted payloads run
    issue(2'b11, 3'd0, 5'd1, 5'd0, 5'd7, 64'h10, 1, 1, K_WB, 64'h50, 0, 0, 3);
    issue(2'b11, 3'd4, 5'd1, 5'd0, 5'd8, 64'hFF, 1, 1, K_WB, 64'hBF, 0, 0, 3);
    issue(2'b00, 3'd3, 5'd2, 5'd1, 5'd9, 64'h0, 0, 1, K_WB, 64'hDEED, 0, 0, 3);

    // reset in MEM_WAIT of a LOAD: aborted, no write afterwards
    preload(5'd10, 64'h55);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_alu_op = 3'd0;
    cmd_rs1 = 5'd1; cmd_rs2 = 5'd0; cmd_rd = 5'd10; cmd_imm = 64'h8;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midop");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("r10_untouched", rf[10], 64'h55);
    chk("post_reset_ready", cmd_ready, 1'b1);

    // overflow on reg-imm add
    preload(5'd12, 64'h7FFF_FFFF_FFFF_FFFF);
    preload(5'd5, 64'h1234);
`ifdef OVERFLOW_TRAP_EN
    issue(2'b11, 3'd0, 5'd12, 5'd0, 5'd5, 64'h1, 0, 0, K_NOWB, 0, 1, 0, 3);
    repeat (4) @(negedge clk);
    chk("trap_set", trap, 1'b1);
    chk("trap_blocks_ready", cmd_ready, 1'b0);
    chk("r5_unchanged", rf[5], 64'h1234);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("trap_cleared", trap, 1'b0);
    chk("ready_after_trap_reset", cmd_ready, 1'b1);
`else
    issue(2'b11, 3'd0, 5'd12, 5'd0, 5'd5, 64'h1, 0, 1, K_WB,
          64'h8000_0000_0000_0000, 1, 0, 3);
    chk("r5_wrapped", rf[5], 64'h8000_0000_0000_0000);
    chk("trap_tied_low", trap, 1'b0);
`endif

    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard_drained", W'(q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
